dct_transpose_buffer: RTL and testbench



---
 rtl/dct_transpose_buffer_if.sv | 25 ++
 rtl/dct_transpose_buffer.sv | 87 ++++++++
 tb/tb_dct_transpose_buffer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dct_transpose_buffer_if.sv
// Row-in / column-out handshake bundle for the DCT transpose buffer.
// The slave side is the buffer; the master side feeds rows and drains columns.
interface dct_transpose_buffer_if #(
  parameter int DW = 9,
  parameter int N  = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N*DW-1:0]        in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*DW-1:0]        out_data;
  logic [$clog2(N)-1:0]   count1;
  logic                   out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count1, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count1, out_last
  );
endinterface

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory between the row DCT pass and DCT_second.
// Rows are written into one bank while columns of the other bank are read out.
module dct_transpose_buffer #(
  parameter int DW = 9,
  parameter int N  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dct_transpose_buffer_if.slave bus
);
  localparam int            AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [N*DW-1:0] mem [2][N];

  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_row;
  logic [AW-1:0] rd_col;
  logic [1:0]    full;
  logic [1:0]    full_next;
  logic          wr_fire;
  logic          rd_fire;
  logic [AW-1:0] elem_sel;

  assign bus.in_ready  = !full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.count1    = rd_col;
  assign bus.out_last  = full[rd_bank] && (rd_col == LAST);

  assign wr_fire  = bus.in_valid && !full[wr_bank];
  assign rd_fire  = full[rd_bank] && bus.out_ready;
  // Element 0 sits in the MSBs of a row, so column c lives at slice N-1-c.
  assign elem_sel = LAST - rd_col;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_row] <= bus.in_data;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int r = 0; r < N; r++) begin
      bus.out_data[(N-1-r)*DW +: DW] = mem[rd_bank][r][elem_sel*DW +: DW];
    end
  end

  // Filling one bank and draining the other can both finish in the same cycle.
  always_comb begin
    full_next = full;
    if (wr_fire && (wr_row == LAST)) begin
      full_next[wr_bank] = 1'b1;
    end
    if (rd_fire && (rd_col == LAST)) begin
      full_next[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_row  <= '0;
      rd_bank <= 1'b0;
      rd_col  <= '0;
      full    <= '0;
    end else begin
      full <= full_next;
      if (wr_fire) begin
        if (wr_row == LAST) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_col == LAST) begin
          rd_col  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed self-checking bench for dct_transpose_buffer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dct_transpose_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dct_transpose_buffer_if bus ();

  dct_transpose_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Element (r,c) of a seeded block is seed*64 + 8r + c, truncated to 9 bits.
  function automatic logic [71:0] rowSeed(int seed, int r);
    logic [71:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[(7-c)*9 +: 9] = 9'(seed*64 + 8*r + c);
    return v;
  endfunction

  function automatic logic [71:0] colSeed(int seed, int c);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) v[(7-r)*9 +: 9] = 9'(seed*64 + 8*r + c);
    return v;
  endfunction

  task automatic checkOutput(string tag, logic [71:0] actual, logic [71:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(logic iv, logic [71:0] id, logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expectIdle(string tag);
    checkOutput({tag, "_in_ready"},  72'(bus.in_ready),  72'(1));
    checkOutput({tag, "_out_valid"}, 72'(bus.out_valid), 72'(0));
    checkOutput({tag, "_count1"},    72'(bus.count1),    72'(0));
    checkOutput({tag, "_out_last"},  72'(bus.out_last),  72'(0));
  endtask

  task automatic expectColumn(string tag, logic [71:0] exp, int c);
    checkOutput({tag, "_valid"},  72'(bus.out_valid), 72'(1));
    checkOutput({tag, "_count1"}, 72'(bus.count1),    72'(c));
    checkOutput({tag, "_last"},   72'(bus.out_last),  72'(c == 7));
    checkOutput({tag, "_data"},   bus.out_data,       exp);
  endtask

  initial begin
    logic [71:0] row;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    $display("[TB] start");

    repeat (2) @(negedge clk);
    expectIdle("reset");
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    expectIdle("idle");

    // Basic transpose: element (r,c) = 8r+c
    for (int r = 0; r < 8; r++) begin
      checkOutput("basic_in_ready", 72'(bus.in_ready), 72'(1));
      checkOutput("basic_no_valid", 72'(bus.out_valid), 72'(0));
      applyStimulus(1'b1, rowSeed(0, r), 1'b1);
    end
    for (int c = 0; c < 8; c++) begin
      expectColumn("basic", colSeed(0, c), c);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("basic_done", 72'(bus.out_valid), 72'(0));

    // Sign extremes: row 0 = -256, row 7 = +255
    for (int r = 0; r < 8; r++) begin
      row = (r == 0) ? {8{9'h100}} : (r == 7) ? {8{9'h0FF}} : 72'd0;
      applyStimulus(1'b1, row, 1'b1);
    end
    for (int c = 0; c < 8; c++) begin
      expectColumn("sign", {9'h100, 54'd0, 9'h0FF}, c);
      applyStimulus(1'b0, '0, 1'b1);
    end

    // Backpressure: two blocks with the reader stalled
    for (int k = 0; k < 16; k++) begin
      checkOutput("bp_in_ready", 72'(bus.in_ready), 72'(1));
      applyStimulus(1'b1, rowSeed(1 + k/8, k%8), 1'b0);
    end
    for (int h = 0; h < 3; h++) begin
      checkOutput("bp_full_in_ready", 72'(bus.in_ready), 72'(0));
      expectColumn("bp_hold", colSeed(1, 0), 0);
      applyStimulus(1'b1, 72'hA5A5_5A5A_A5A5_5A5A_A5, 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      checkOutput("bp_drain_in_ready", 72'(bus.in_ready), 72'(k >= 8));
      expectColumn("bp_drain", colSeed(1 + k/8, k%8), k%8);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("bp_empty", 72'(bus.out_valid), 72'(0));

    // Streaming: four blocks back-to-back
    for (int k = 0; k < 40; k++) begin
      if (k < 32) checkOutput("st_in_ready", 72'(bus.in_ready), 72'(1));
      if (k < 8) checkOutput("st_no_valid", 72'(bus.out_valid), 72'(0));
      else expectColumn("st", colSeed(3 + (k-8)/8, (k-8)%8), (k-8)%8);
      applyStimulus(k < 32, (k < 32) ? rowSeed(3 + k/8, k%8) : 72'd0, 1'b1);
    end
    checkOutput("st_done", 72'(bus.out_valid), 72'(0));

    // Reset while one bank is partly read and the other partly written
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1'b1, (k < 8) ? rowSeed(7, k) : rowSeed(2, k-8), 1'b0);
    end
    for (int c = 0; c < 3; c++) begin
      expectColumn("mr_pre", colSeed(7, c), c);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("mr_col3", 72'(bus.count1), 72'(3));
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 expectIdle("mr_async");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    expectIdle("mr_after");
    for (int r = 0; r < 8; r++) begin
      checkOutput("mr_no_valid", 72'(bus.out_valid), 72'(0));
      applyStimulus(1'b1, rowSeed(5, r), 1'b1);
    end
    for (int c = 0; c < 8; c++) begin
      expectColumn("mr_clean", colSeed(5, c), c);
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("mr_done", 72'(bus.out_valid), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
